// File: rtl/flash_ctrl.sv
// Word-to-halfword flash initiator: splits each 32-bit request into two 16-bit flash
// accesses (low half first), with a ce gap between them and a per-halfword ready timeout.
`timescale 1ns/1ps
module flash_ctrl #(
   parameter int ADDR_W  = 23,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-2:0] mem_addr_i,
   input  logic [31:0]       mem_data_i,
   output logic [31:0]       mem_data_o,
   output logic              mem_ready_o,
   output logic              mem_err_o,
   output logic              mem_busy_o,
   output logic [ADDR_W-1:0] flash_addr_o,
   output logic              flash_ce_o,
   output logic              flash_we_o,
   output logic [15:0]       flash_data_o,
   input  logic [15:0]       flash_data_i,
   input  logic              flash_ready_i
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LO, GAP1, HI, GAP2, ERR} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W-2:0] addr_reg, addr_next;
   logic              we_reg, we_next;
   logic [31:0]       data_reg, data_next;
   logic [31:0]       rdata_reg, rdata_next;
   logic              timed_out;
   logic              in_access;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         data_reg  <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         we_reg    <= we_next;
         data_reg  <= data_next;
         rdata_reg <= rdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      we_next    = we_reg;
      data_next  = data_reg;
      rdata_next = rdata_reg;
      timed_out  = (cnt_reg == CNT_LAST);

      case (state_reg)
         IDLE: begin
            if (mem_ce_i) begin
               addr_next  = mem_addr_i;
               we_next    = mem_we_i;
               data_next  = mem_data_i;
               cnt_next   = '0;
               state_next = LO;
            end
         end
         LO: begin
            if (flash_ready_i) begin
               if (!we_reg) data_next[15:0] = flash_data_i;
               state_next = GAP1;
            end else if (timed_out) begin
               state_next = ERR;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         // One ce-low cycle lets the registered ready from LO fall before HI looks at it.
         GAP1: begin
            cnt_next   = '0;
            state_next = HI;
         end
         HI: begin
            if (flash_ready_i) begin
               if (!we_reg) rdata_next = {flash_data_i, data_reg[15:0]};
               state_next = GAP2;
            end else if (timed_out) begin
               state_next = ERR;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         GAP2:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Outputs decode straight from registered state so reset drops them immediately.
      in_access    = (state_reg == LO) || (state_reg == HI);
      flash_ce_o   = in_access;
      flash_we_o   = in_access && we_reg;
      flash_addr_o = in_access ? {addr_reg, (state_reg == HI)} : '0;
      flash_data_o = '0;
      if (in_access && we_reg)
         flash_data_o = (state_reg == HI) ? data_reg[31:16] : data_reg[15:0];
      mem_ready_o  = (state_reg == GAP2) || (state_reg == ERR);
      mem_err_o    = (state_reg == ERR);
      mem_busy_o   = (state_reg != IDLE);
   end

   assign mem_data_o = rdata_reg;

endmodule
